// File: rtl/n29_pkg.sv
// n29_pkg: shared widths, FSM state type and helpers for the AN(29)
// correction scheduler.
//   N_LANES : codewords per 4x4 block
//   CW_W    : codeword width
//   Q_W     : message / Barrett quotient width
//   R_W     : Barrett remainder width
//   AN_Q_W  : quotient width seen by the shared AN decoder
package n29_pkg;

  localparam int N_LANES = 16;
  localparam int CW_W    = 14;
  localparam int Q_W     = 10;
  localparam int R_W     = 5;
  localparam int AN_Q_W  = 14;
  localparam int IDX_W   = 4;
  localparam int AN_A    = 29;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturating 16-bit add used by the status counters.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/an_decoder_n29.sv
// an_decoder_n29: single arithmetic-error corrector for the AN code A=29.
//   q   : Barrett quotient (zero-extended)
//   r   : Barrett remainder
//   msg : corrected message
// 2 is a primitive root mod 29, so the 28 residues of +/-2^j (j = 0..13)
// are all distinct and every non-zero remainder names exactly one error.
module an_decoder_n29
  import n29_pkg::*;
(
  input  logic [AN_Q_W-1:0] q,
  input  logic [R_W-1:0]    r,
  output logic [Q_W-1:0]    msg
);

  logic [AN_Q_W-1:0] adj;

  // Error +2^j: message = q - floor(2^j/29).
  // Error -2^j: message = q + floor(2^j/29) + 1.
  always_comb begin
    adj = '0;
    for (int j = 0; j < CW_W; j++) begin
      if (r == R_W'((1 << j) % AN_A)) begin
        adj = AN_Q_W'(0) - AN_Q_W'((1 << j) / AN_A);
      end else if (r == R_W'(AN_A - ((1 << j) % AN_A))) begin
        adj = AN_Q_W'((1 << j) / AN_A + 1);
      end
    end
    msg = Q_W'(q + adj);
  end

endmodule

// File: rtl/barrett_n29.sv
// barrett_n29: combinational divide-by-29 of one 14-bit codeword.
//   cw    : input codeword
//   q     : floor(cw / 29)
//   r     : cw mod 29
//   error : remainder non-zero (codeword is not a multiple of 29)
module barrett_n29
  import n29_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  output logic [Q_W-1:0]  q,
  output logic [R_W-1:0]  r,
  output logic            error
);

  // floor(2^16 / 29); the estimate is at most one below the true quotient
  // over the full 14-bit input range, so a single correction step suffices.
  localparam logic [25:0] MU = 26'd2259;

  logic [25:0]     prod;
  logic [Q_W-1:0]  q_est;
  logic [CW_W-1:0] q_times_a;
  logic [CW_W-1:0] rem_est;

  always_comb begin
    prod      = 26'(cw) * MU;
    q_est     = Q_W'(prod >> 16);
    q_times_a = CW_W'(q_est) * CW_W'(AN_A);
    rem_est   = cw - q_times_a;
    if (rem_est >= CW_W'(AN_A)) begin
      q = q_est + Q_W'(1);
      r = R_W'(rem_est - CW_W'(AN_A));
    end else begin
      q = q_est;
      r = R_W'(rem_est);
    end
    error = (r != '0);
  end

endmodule

// File: rtl/n29_lane_pick.sv
// n29_lane_pick: lowest-set-bit priority encoder over the pending mask.
//   req : request mask, one bit per lane
//   idx : index of the lowest set bit (0 when none)
//   any : at least one bit set
module n29_lane_pick
  import n29_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/n29_corr_sched.sv
// n29_corr_sched: accepts a 4x4 block of AN(29) codewords, divides all 16
// lanes in parallel, then corrects flagged lanes one per cycle through a
// single shared decoder, lowest lane first, up to MAX_CORR lanes.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : block input handshake, in_cw = 16 x 14-bit lanes
//   out_valid/out_ready : result handshake
//   out_msg             : 16 x 10-bit messages
//   out_err_map         : lanes whose remainder was non-zero
//   out_uncorr          : flagged lanes left uncorrected by the MAX_CORR cap
//   stat_*              : delivered blocks / corrected lanes / capped blocks
// Macro N29_STAT_EN enables the saturating status counters; without it the
// stat_* ports are tied to zero.
module n29_corr_sched
  import n29_pkg::*;
#(
  parameter int MAX_CORR = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_LANES*CW_W-1:0]  in_cw,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LANES*Q_W-1:0]   out_msg,
  output logic [N_LANES-1:0]       out_err_map,
  output logic                     out_uncorr,
  output logic [15:0]              stat_blocks,
  output logic [15:0]              stat_corr,
  output logic [15:0]              stat_uncorr
);

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CORR);

  state_t state_q, state_d;

  logic [Q_W-1:0]     msg_q [N_LANES];
  logic [R_W-1:0]     rem_q [N_LANES];
  logic [N_LANES-1:0] pending_q;
  logic [N_LANES-1:0] err_map_q;
  logic [CNT_W-1:0]   corr_cnt_q;
  logic               uncorr_q;

  logic [Q_W-1:0]     bar_q   [N_LANES];
  logic [R_W-1:0]     bar_r   [N_LANES];
  logic [N_LANES-1:0] bar_err;

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;
  logic [AN_Q_W-1:0]  dec_q;
  logic [Q_W-1:0]     dec_msg;
  logic [N_LANES-1:0] pending_next;
  logic [CNT_W-1:0]   cnt_next;

  logic capture;
  logic correct;
  logic finish;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    barrett_n29 u_barrett (
      .cw    (in_cw[i*CW_W +: CW_W]),
      .q     (bar_q[i]),
      .r     (bar_r[i]),
      .error (bar_err[i])
    );
  end

  n29_lane_pick u_pick (
    .req (pending_q),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Uncorrected lanes still hold their raw quotient in the message register,
  // so that register doubles as the decoder's quotient source.
  assign dec_q = AN_Q_W'(msg_q[sel_idx]);

  an_decoder_n29 u_decoder (
    .q   (dec_q),
    .r   (rem_q[sel_idx]),
    .msg (dec_msg)
  );

  assign pending_next = pending_q & ~(N_LANES'(1) << sel_idx);
  assign cnt_next     = corr_cnt_q + CNT_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes. An empty mask on entry to SCAN still
  // spends one cycle there so latency is never below one cycle.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    correct = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!sel_any) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          correct = 1'b1;
          if ((pending_next == '0) || (cnt_next == CNT_MAX)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Block datapath: capture all lanes, then overwrite one lane per
  // correction. Any pending bit left when SCAN ends marks the block capped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LANES; i++) begin
        msg_q[i] <= '0;
        rem_q[i] <= '0;
      end
      pending_q  <= '0;
      err_map_q  <= '0;
      corr_cnt_q <= '0;
      uncorr_q   <= 1'b0;
    end else begin
      if (capture) begin
        for (int i = 0; i < N_LANES; i++) begin
          msg_q[i] <= bar_q[i];
          rem_q[i] <= bar_r[i];
        end
        pending_q  <= bar_err;
        err_map_q  <= bar_err;
        corr_cnt_q <= '0;
        uncorr_q   <= 1'b0;
      end
      if (correct) begin
        msg_q[sel_idx] <= dec_msg;
        pending_q      <= pending_next;
        corr_cnt_q     <= cnt_next;
      end
      if (finish) begin
        uncorr_q <= |pending_next;
      end
    end
  end

  always_comb begin
    out_msg = '0;
    for (int i = 0; i < N_LANES; i++) begin
      out_msg[i*Q_W +: Q_W] = msg_q[i];
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_err_map = err_map_q;
  assign out_uncorr  = uncorr_q;

`ifdef N29_STAT_EN
  logic [15:0] blocks_q;
  logic [15:0] corr_q;
  logic [15:0] unc_q;

  // Counters advance on the delivery handshake; corr_cnt_q still holds k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocks_q <= '0;
      corr_q   <= '0;
      unc_q    <= '0;
    end else if (out_valid && out_ready) begin
      blocks_q <= sat_add16(blocks_q, 16'd1);
      corr_q   <= sat_add16(corr_q, 16'(corr_cnt_q));
      unc_q    <= sat_add16(unc_q, 16'(uncorr_q));
    end
  end

  assign stat_blocks = blocks_q;
  assign stat_corr   = corr_q;
  assign stat_uncorr = unc_q;
`else
  assign stat_blocks = '0;
  assign stat_corr   = '0;
  assign stat_uncorr = '0;
`endif

endmodule
